// File: rtl/srv32_mem_pkg.sv
// Shared definitions for the srv32 memory responders (dmem/imem).
package srv32_mem_pkg;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int unsigned MAX_LATENCY  = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rd_pipe_t;

  // Fibonacci step for x^16+x^14+x^13+x^11+1: taps are state bits 15,13,12,10.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/srv32_dmem_responder_if.sv
// srv32 data-memory port: the core is the master, the responder the slave.
interface srv32_dmem_responder_if;

  logic        dmem_wready;
  logic        dmem_wvalid;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rready;
  logic        dmem_rvalid;
  logic [31:0] dmem_raddr;
  logic        dmem_rresp;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb,
    output dmem_rready, dmem_raddr,
    input  dmem_wvalid, dmem_rvalid, dmem_rresp, dmem_rdata
  );

  modport slave (
    input  dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb,
    input  dmem_rready, dmem_raddr,
    output dmem_wvalid, dmem_rvalid, dmem_rresp, dmem_rdata
  );

endinterface

// File: rtl/srv32_stall_lfsr.sv
// Free-running 16-bit LFSR used to generate pseudo-random backpressure.
module srv32_stall_lfsr
  import srv32_mem_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= SEED;
    end else if (en) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/srv32_dmem_responder.sv
// Data-memory responder: byte-write RAM with a fixed-latency read pipeline
// and optional LFSR-driven acceptance stalls.
module srv32_dmem_responder
  import srv32_mem_pkg::*;
#(
  parameter int unsigned SIZE       = 65536,
  parameter int unsigned LATENCY    = 1,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [15:0] STALL_SEED = DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  resetb,
  srv32_dmem_responder_if.slave dmem
);

  localparam int unsigned AW    = $clog2(SIZE);
  localparam int unsigned WORDS = SIZE / 4;

  logic [31:0]   mem [WORDS];
  logic [AW-3:0] widx;
  logic [AW-3:0] ridx;
  logic          wacc;
  logic          racc;
  logic          wvalid_q;
  logic          rvalid_q;
  logic [15:0]   lfsr_state;
  logic [15:0]   lfsr_nxt;
  rd_pipe_t      pipe [LATENCY];
  logic          unused_bits;

  srv32_stall_lfsr #(
    .SEED (STALL_SEED)
  ) u_lfsr (
    .clk    (clk),
    .resetb (resetb),
    .en     (STALL_EN),
    .state  (lfsr_state)
  );

  // Readies are registered from the LFSR's next value so they track the live
  // LFSR state while coming up one edge after reset release.
  always_comb lfsr_nxt = lfsr_step(lfsr_state);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wvalid_q <= STALL_EN ? lfsr_nxt[0] : 1'b1;
      rvalid_q <= STALL_EN ? lfsr_nxt[1] : 1'b1;
    end
  end

  always_comb begin
    wacc = dmem.dmem_wready & wvalid_q;
    racc = dmem.dmem_rready & rvalid_q;
    widx = dmem.dmem_waddr[AW-1:2];
    ridx = dmem.dmem_raddr[AW-1:2];
  end

  // Array is intentionally left out of reset so contents survive resetb.
  always_ff @(posedge clk) begin
    if (wacc) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (dmem.dmem_wstrb[b]) begin
          mem[widx][8*b +: 8] <= dmem.dmem_wdata[8*b +: 8];
        end
      end
    end
  end

  // The read samples the array with the same edge as any write, so a
  // same-word collision returns pre-write data.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{valid: racc, data: mem[ridx]};
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_comb begin
    dmem.dmem_wvalid = wvalid_q;
    dmem.dmem_rvalid = rvalid_q;
    dmem.dmem_rresp  = pipe[LATENCY-1].valid;
    dmem.dmem_rdata  = pipe[LATENCY-1].data;
  end

  assign unused_bits = ^{dmem.dmem_waddr[31:AW], dmem.dmem_waddr[1:0],
                         dmem.dmem_raddr[31:AW], dmem.dmem_raddr[1:0],
                         lfsr_nxt[15:2]};

endmodule

// File: doc/srv32_dmem_responder.md
# srv32_dmem_responder

Data-memory responder for the srv32 core's data RAM interface: accepts write and read requests, stores data in an internal byte-addressable array, and returns read data after a fixed pipelined latency. It sits in the top level opposite the core's dmem port, replacing an ideal RAM model. An optional pseudo-random stall generator withdraws acceptance so the core's handshake logic is exercised under backpressure.

## Interface
- SIZE, 65536 — memory size in bytes; power of two, ≥ 4.
- LATENCY, 1 — read latency in cycles from request acceptance to dmem_rresp; legal range 1..4.
- STALL_EN, 0 — 1 enables LFSR-driven deassertion of dmem_wvalid/dmem_rvalid.
- STALL_SEED, 16'hACE1 — LFSR reset value; must be nonzero.
- Reset is asynchronous and active-low; one clock.
- clk  in  1  clock; all state updates on the rising edge.
- resetb  in  1  asynchronous active-low reset.
- dmem_wready  in  1  core write request.
- dmem_wvalid  out  1  responder can accept a write this cycle.
- dmem_waddr  in  32  write byte address.
- dmem_wdata  in  32  write data, little-endian lanes.
- dmem_wstrb  in  4  byte enables; bit i enables wdata[8i+7:8i].
- dmem_rready  in  1  core read request.
- dmem_rvalid  out  1  responder can accept a read this cycle.
- dmem_raddr  in  32  read byte address.
- dmem_rresp  out  1  read data valid; one-cycle pulse per accepted read.
- dmem_rdata  out  32  read data; valid only while dmem_rresp=1.

## Operation
- Write accepted when dmem_wready & dmem_wvalid. Word index = waddr[log2(SIZE)-1:2]. Upper address bits are ignored, so addresses wrap modulo SIZE. waddr[1:0] is ignored. Only the strobed bytes update. wstrb=0 is accepted with no effect.
- Read accepted when dmem_rready & dmem_rvalid. The word is sampled from the array in the acceptance cycle and enters a LATENCY-deep valid/data shift pipeline.
- One read and one write may be accepted in the same cycle. If they address the same word, the read returns pre-write data (read-before-write).
- The core applies no backpressure on responses. Responses are in order, one per accepted read, and back-to-back reads yield back-to-back rresp pulses.
- Ready generation:
  - STALL_EN=0: dmem_wvalid = dmem_rvalid = 1 whenever out of reset.
  - STALL_EN=1: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances every cycle. dmem_wvalid = lfsr[0], dmem_rvalid = lfsr[1].
- Array contents are not reset; they are undefined until written.

## Timing
- Reset values:
  - dmem_wvalid, dmem_rvalid, and dmem_rresp = 0.
  - dmem_rdata = 0.
  - The pipeline is cleared.
  - LFSR = STALL_SEED.
- First acceptance is possible in the first cycle after resetb deasserts; the ready outputs are registered, so they rise one edge after release.
- A read accepted at edge N produces dmem_rresp=1 and data in the cycle after edge N+LATENCY−1. With LATENCY=1, data is presented in the cycle following acceptance.
- A write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Reset asserted mid-operation drops all in-flight reads, so no rresp is produced for them. Array contents are retained.
- Ready outputs do not depend combinationally on dmem_wready or dmem_rready.

## Structure
- Shared package srv32_mem_pkg:
  - LFSR tap mask constant 16'hB400.
  - Default seed constant.
  - MAX_LATENCY=4 constant.
  - rd_pipe_t struct holding the valid bit and 32-bit data.
- Sub-module srv32_stall_lfsr (seed parameter, en input, 16-bit state output), reusable for an imem responder.
- The array is a plain reg array inferred as RAM with byte-write enables.

## Test plan
- Write 0xDEADBEEF to 0x100 with wstrb=4'hF, then read 0x100 at LATENCY=1 → one rresp pulse one cycle after acceptance, rdata=0xDEADBEEF.
- Partial write: write wstrb=4'b0101 with data 0x11223344 over 0xDEADBEEF at 0x100, then read → 0xDE22BE44.
- Wrap and same-cycle access: with SIZE=65536, write 0xA5A5A5A5 to 0x10000 → read of 0x0 returns 0xA5A5A5A5. A same-cycle read and write to 0x0 (new data 0x1) returns 0xA5A5A5A5, and the next read returns 0x1.
- LATENCY=3 back-to-back reads of 0x0, 0x4, 0x8 on consecutive edges → three consecutive rresp pulses in order, with the first appearing three cycles after the first acceptance.
- STALL_EN=1 with seed 0xACE1: over 1000 random requests, every accepted request completes, no request is accepted while its valid output is low, and read data matches the scoreboard.
- Assert resetb low with two reads in flight at LATENCY=4 → no rresp after reset, ready outputs are 0 during reset, and previously written data is still readable afterwards.
